ether_bytes: RTL and testbench

//  Downstream stage of the RMII preamble/SFD stripper. Consumes its post-SFD dibit stream
//  (axiiv/axiid, 2 bits/cycle) and packs dibits LSB-first into bytes. Runs a CRC-32 (IEEE
//  802.3) over every dibit, FCS included. Emits per-frame status (crc_ok, align_err, runt,

---
 rtl/ether_pkg.sv | 25 ++
 rtl/ether_bytes_if.sv | 42 ++++
 rtl/crc32_rmii.sv | 26 ++
 rtl/ether_bytes.sv | 129 ++++++++++++
 tb/tb_ether_bytes.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/ether_pkg.sv
// Shared constants, state type and CRC-32 helper for the RMII receive/transmit paths.
package ether_pkg;

  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  // Running CRC over data plus a correct FCS (no final XOR) lands on this value.
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

  typedef enum logic {IDLE, RECV} ebytes_state_t;

  // Reflected CRC-32 advanced by one dibit, bit 0 of the dibit first.
  function automatic logic [31:0] crc32_dibit(input logic [31:0] crc, input logic [1:0] dibit);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++) begin
      if (c[0] ^ dibit[i]) begin
        c = (c >> 1) ^ CRC_POLY_REFL;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/ether_bytes_if.sv
// Dibit input stream from the preamble/SFD stripper plus the byte and frame status outputs.
interface ether_bytes_if #(
  parameter int unsigned CNT_W = 16
);

  logic             axiiv;
  logic [1:0]       axiid;
  logic             axiov;
  logic [7:0]       axiod;
  logic             frame_done;
  logic             crc_ok;
  logic             align_err;
  logic             runt;
  logic [CNT_W-1:0] byte_count;

  // Upstream side: drives dibits, observes bytes and status.
  modport master (
    output axiiv,
    output axiid,
    input  axiov,
    input  axiod,
    input  frame_done,
    input  crc_ok,
    input  align_err,
    input  runt,
    input  byte_count
  );

  // Byte packer side.
  modport slave (
    input  axiiv,
    input  axiid,
    output axiov,
    output axiod,
    output frame_done,
    output crc_ok,
    output align_err,
    output runt,
    output byte_count
  );

endinterface

// File: rtl/crc32_rmii.sv
// CRC-32 register advanced one dibit per enabled cycle; init restarts from CRC_INIT.
module crc32_rmii
  import ether_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [1:0]  dibit,
  output logic [31:0] crc
);

  logic [31:0] r_crc;

  // CRC state: on init the current dibit is folded into a fresh CRC_INIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_crc <= CRC_INIT;
    end else if (en) begin
      r_crc <= crc32_dibit(init ? CRC_INIT : r_crc, dibit);
    end
  end

  assign crc = r_crc;

endmodule

// File: rtl/ether_bytes.sv
// Packs the post-SFD RMII dibit stream into bytes (LSB dibit first), checks the FCS
// residue and reports per-frame status one cycle after the stream drops.
module ether_bytes
  import ether_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned MIN_LEN = 64
) (
  input logic          clk,
  input logic          rst,
  ether_bytes_if.slave bus
);

  ebytes_state_t    r_state, w_state_d;
  logic [1:0]       r_idx, w_idx_d;
  // Only the three most recent dibits need keeping; the fourth arrives on the input.
  logic [5:0]       r_sr, w_sr_d;
  logic [CNT_W-1:0] r_count, w_count_d;
  logic             r_axiov, w_axiov_d;
  logic [7:0]       r_axiod, w_axiod_d;
  logic             r_done, w_done_d;
  logic             r_crc_ok, w_crc_ok_d;
  logic             r_align, w_align_d;
  logic             r_runt, w_runt_d;

  logic             w_crc_init;
  logic             w_crc_en;
  logic [31:0]      w_crc;

  crc32_rmii u_crc (
    .clk   (clk),
    .rst   (rst),
    .init  (w_crc_init),
    .en    (w_crc_en),
    .dibit (bus.axiid),
    .crc   (w_crc)
  );

  // Next-state logic: frame start, dibit packing, byte emission and end-of-frame status.
  always_comb begin
    w_state_d  = r_state;
    w_idx_d    = r_idx;
    w_sr_d     = r_sr;
    w_count_d  = r_count;
    w_axiov_d  = 1'b0;
    w_axiod_d  = r_axiod;
    w_done_d   = 1'b0;
    w_crc_ok_d = r_crc_ok;
    w_align_d  = r_align;
    w_runt_d   = r_runt;
    w_crc_init = 1'b0;
    w_crc_en   = 1'b0;

    unique case (r_state)
      IDLE: begin
        // Also covers the frame_done cycle of a preceding frame, so back-to-back
        // frames lose no dibits.
        if (bus.axiiv) begin
          w_state_d  = RECV;
          w_idx_d    = 2'd1;
          w_sr_d     = {bus.axiid, r_sr[5:2]};
          w_count_d  = '0;
          w_crc_init = 1'b1;
          w_crc_en   = 1'b1;
        end
      end
      RECV: begin
        if (bus.axiiv) begin
          w_sr_d   = {bus.axiid, r_sr[5:2]};
          w_idx_d  = r_idx + 2'd1;
          w_crc_en = 1'b1;
          if (r_idx == 2'd3) begin
            w_axiov_d = 1'b1;
            w_axiod_d = {bus.axiid, r_sr};
            if (r_count != '1) begin
              w_count_d = r_count + CNT_W'(1);
            end
          end
        end else begin
          // First idle cycle: count and CRC already include the last whole byte.
          w_state_d  = IDLE;
          w_done_d   = 1'b1;
          w_align_d  = (r_idx != 2'd0);
          w_crc_ok_d = (w_crc == CRC_RESIDUE) && (r_idx == 2'd0);
          w_runt_d   = (r_count < CNT_W'(MIN_LEN));
        end
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= 2'd0;
      r_sr     <= '0;
      r_count  <= '0;
      r_axiov  <= 1'b0;
      r_axiod  <= '0;
      r_done   <= 1'b0;
      r_crc_ok <= 1'b0;
      r_align  <= 1'b0;
      r_runt   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_idx    <= w_idx_d;
      r_sr     <= w_sr_d;
      r_count  <= w_count_d;
      r_axiov  <= w_axiov_d;
      r_axiod  <= w_axiod_d;
      r_done   <= w_done_d;
      r_crc_ok <= w_crc_ok_d;
      r_align  <= w_align_d;
      r_runt   <= w_runt_d;
    end
  end

  assign bus.axiov      = r_axiov;
  assign bus.axiod      = r_axiod;
  assign bus.frame_done = r_done;
  assign bus.crc_ok     = r_crc_ok;
  assign bus.align_err  = r_align;
  assign bus.runt       = r_runt;
  assign bus.byte_count = r_count;

endmodule

// File: tb/tb_ether_bytes.sv
// Bench for ether_bytes: table of frames plus back-to-back and mid-frame reset sequences,
// with expected bytes and frame status queued at drive time and checked on DUT output.
module tb_ether_bytes;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned MIN_LEN = 64;

  logic clk = 1'b0;
  logic rst;

  ether_bytes_if #(.CNT_W(CNT_W)) bus ();

  ether_bytes #(
    .CNT_W   (CNT_W),
    .MIN_LEN (MIN_LEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;

  typedef struct {
    bit ok;
    bit align;
    bit runt;
    int cnt;
  } stat_t;

  typedef struct {
    int    kind;     // 0: "123456789" + FCS, 1: 60 zero bytes + FCS
    bit    corrupt;  // flip bit 0 of the last FCS byte
    int    ndib;     // dibits to send; 0 means the whole frame
    stat_t st;
  } vec_t;

  stat_t      q_stat[$];
  logic [7:0] q_byte[$];
  logic [7:0] tx[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Bitwise reflected CRC-32 with final inversion: the FCS a transmitter appends.
  function automatic logic [31:0] fcs_of(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        if (c[0] ^ b[i][k]) c = (c >> 1) ^ 32'hEDB8_8320;
        else                c = c >> 1;
      end
    end
    return ~c;
  endfunction

  task automatic build(input int kind, input bit corrupt);
    logic [31:0] f;
    tx.delete();
    if (kind == 0) begin
      for (int i = 0; i < 9; i++) tx.push_back(8'h31 + 8'(i));
      tx.push_back(8'h26);
      tx.push_back(8'h39);
      tx.push_back(8'hF4);
      tx.push_back(8'hCB);
    end else begin
      for (int i = 0; i < 60; i++) tx.push_back(8'h00);
      f = fcs_of(tx);
      for (int i = 0; i < 4; i++) tx.push_back(f[8*i +: 8]);
    end
    if (corrupt) tx[tx.size()-1] = tx[tx.size()-1] ^ 8'h01;
  endtask

  // Entered at a negedge; leaves at the negedge after the last driven cycle.
  task automatic drive_frame(input int ndib, input int gap, input stat_t st);
    logic [7:0] b;
    for (int i = 0; i < ndib; i++) begin
      b = tx[i/4];
      bus.axiiv = 1'b1;
      bus.axiid = 2'(b >> (2 * (i % 4)));
      if (i % 4 == 3) q_byte.push_back(b);
      @(negedge clk);
    end
    if (gap > 0) q_stat.push_back(st);
    for (int g = 0; g < gap; g++) begin
      bus.axiiv = 1'b0;
      bus.axiid = 2'd0;
      @(negedge clk);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_axiov"},      bus.axiov,      0);
    chk({tag, "_axiod"},      bus.axiod,      0);
    chk({tag, "_frame_done"}, bus.frame_done, 0);
    chk({tag, "_crc_ok"},     bus.crc_ok,     0);
    chk({tag, "_align_err"},  bus.align_err,  0);
    chk({tag, "_runt"},       bus.runt,       0);
    chk({tag, "_byte_count"}, bus.byte_count, 0);
  endtask

  task automatic monitor();
    stat_t s;
    forever begin
      @(negedge clk);
      if (bus.axiov) begin
        if (q_byte.size() == 0) chk("axiov_unexpected", bus.axiov, 0);
        else                    chk("axiod", bus.axiod, q_byte.pop_front());
      end
      if (bus.frame_done) begin
        if (q_stat.size() == 0) begin
          chk("frame_done_unexpected", bus.frame_done, 0);
        end else begin
          s = q_stat.pop_front();
          chk("crc_ok",     bus.crc_ok,     s.ok);
          chk("align_err",  bus.align_err,  s.align);
          chk("runt",       bus.runt,       s.runt);
          chk("byte_count", bus.byte_count, s.cnt);
        end
      end
    end
  endtask

  initial begin
    vec_t  vecs[5];
    stat_t good13;
    stat_t none;
    int    nd;

    good13 = '{ok: 1'b1, align: 1'b0, runt: 1'b1, cnt: 13};
    none   = '{ok: 1'b0, align: 1'b0, runt: 1'b0, cnt: 0};
    vecs[0] = '{kind: 0, corrupt: 1'b0, ndib: 0,  st: good13};
    vecs[1] = '{kind: 0, corrupt: 1'b1, ndib: 0,  st: '{1'b0, 1'b0, 1'b1, 13}};
    vecs[2] = '{kind: 1, corrupt: 1'b0, ndib: 0,  st: '{1'b1, 1'b0, 1'b0, 64}};
    vecs[3] = '{kind: 0, corrupt: 1'b0, ndib: 50, st: '{1'b0, 1'b1, 1'b1, 12}};
    vecs[4] = '{kind: 0, corrupt: 1'b0, ndib: 1,  st: '{1'b0, 1'b1, 1'b1, 0}};

    rst       = 1'b1;
    bus.axiiv = 1'b0;
    bus.axiid = 2'd0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[v]) begin
      build(vecs[v].kind, vecs[v].corrupt);
      nd = (vecs[v].ndib > 0) ? vecs[v].ndib : tx.size() * 4;
      drive_frame(nd, 3, vecs[v].st);
    end

    // Back-to-back: one idle cycle, second frame starts in the first frame_done cycle.
    build(0, 1'b0);
    drive_frame(52, 1, good13);
    chk("b2b_done_overlap", bus.frame_done, 1);
    drive_frame(52, 3, good13);

    // Reset one cycle after the fifth byte's last dibit; nothing of that frame completes.
    drive_frame(20, 0, none);
    rst       = 1'b1;
    bus.axiiv = 1'b1;
    bus.axiid = tx[5][1:0];
    @(negedge clk);
    chk_all_zero("midreset");
    rst       = 1'b0;
    bus.axiiv = 1'b0;
    bus.axiid = 2'd0;
    repeat (3) @(negedge clk);
    drive_frame(52, 3, good13);

    for (int w = 0; w < 200 && (q_byte.size() != 0 || q_stat.size() != 0); w++) begin
      @(negedge clk);
    end
    chk("pending_bytes",  q_byte.size(), 0);
    chk("pending_status", q_stat.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
